// File: rtl/param_reg_file_if.sv
// Control/data bundle for param_reg_file: write selects, operation code,
// read selects and the two read ports plus status flags.
interface param_reg_file_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NR    = 4,
    parameter int unsigned NT    = 4
);
    localparam int unsigned SW = $clog2(NR + NT);

    logic [WIDTH-1:0] Input;
    logic [2:0]       FunSel;
    logic [NR-1:0]    RSel;
    logic [NT-1:0]    TSel;
    logic [SW-1:0]    O1Sel;
    logic [SW-1:0]    O2Sel;
    logic             ClrOvf;
    logic [WIDTH-1:0] Output1;
    logic [WIDTH-1:0] Output2;
    logic             Zero1;
    logic             Ovf;

    modport master (
        output Input, FunSel, RSel, TSel, O1Sel, O2Sel, ClrOvf,
        input  Output1, Output2, Zero1, Ovf
    );

    modport slave (
        input  Input, FunSel, RSel, TSel, O1Sel, O2Sel, ClrOvf,
        output Output1, Output2, Zero1, Ovf
    );
endinterface

// File: rtl/param_reg_file.sv
// Register file of NT temporary and NR general registers sharing one operation
// code, two combinational read ports and a sticky wrap-around flag.
module param_reg_file #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NR    = 4,
    parameter int unsigned NT    = 4
) (
    input  logic Clock,
    input  logic Reset,
    param_reg_file_if.slave bus
);
    localparam int unsigned NREG = NR + NT;
    localparam int unsigned SW   = $clog2(NREG);
    localparam int unsigned SW1  = SW + 1;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  wr_en;
    logic             ovf_q;
    logic             ovf_d;
    logic             wrap;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;

    // Storage index 0..NT-1 is T1..T(NT), NT.. is R1..R(NR); select MSB is the first register.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NT; i++) wr_en[i] = bus.TSel[NT-1-i];
        for (int unsigned j = 0; j < NR; j++) wr_en[NT+j] = bus.RSel[NR-1-j];
    end

    always_comb begin
        wrap = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                case (bus.FunSel)
                    3'b000: regs_d[i] = '0;
                    3'b001: regs_d[i] = bus.Input;
                    3'b010: regs_d[i] = regs_q[i] - WIDTH'(1);
                    3'b011: regs_d[i] = regs_q[i] + WIDTH'(1);
                    3'b100: regs_d[i] = regs_q[i] << 1;
                    3'b101: regs_d[i] = regs_q[i] >> 1;
                    3'b110: regs_d[i] = (regs_q[i] << 1) | (regs_q[i] >> (WIDTH - 1));
                    default: regs_d[i] = regs_q[i];
                endcase
                if ((bus.FunSel == 3'b010 && regs_q[i] == '0) ||
                    (bus.FunSel == 3'b011 && regs_q[i] == '1))
                    wrap = 1'b1;
            end
        end
        // A wrap on the same edge beats the clear request.
        ovf_d = wrap ? 1'b1 : (bus.ClrOvf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
            ovf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        out1 = '0;
        out2 = '0;
        if ({1'b0, bus.O1Sel} < SW1'(NREG)) out1 = regs_q[bus.O1Sel];
        if ({1'b0, bus.O2Sel} < SW1'(NREG)) out2 = regs_q[bus.O2Sel];
    end

    assign bus.Output1 = out1;
    assign bus.Output2 = out2;
    assign bus.Zero1   = (out1 == '0);
    assign bus.Ovf     = ovf_q;
endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: a vector table for single-edge operations
// plus hand sequences for reset-in-flight and out-of-range reads.
module tb_param_reg_file;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_reg_file_if #(.WIDTH(8), .NR(4), .NT(4)) bus  ();
    param_reg_file_if #(.WIDTH(8), .NR(3), .NT(3)) bus3 ();

    param_reg_file #(.WIDTH(8), .NR(4), .NT(4)) dut  (.Clock(clk), .Reset(rst_n), .bus(bus.slave));
    param_reg_file #(.WIDTH(8), .NR(3), .NT(3)) dut3 (.Clock(clk), .Reset(rst_n), .bus(bus3.slave));

    typedef struct {
        logic [2:0] fs;
        logic [3:0] rsel;
        logic [3:0] tsel;
        logic [7:0] din;
        logic       clr;
        logic [2:0] o1;
        logic [2:0] o2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ez;
        logic       eov;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle4();
        bus.FunSel = 3'b111; bus.RSel = '0; bus.TSel = '0; bus.Input = '0; bus.ClrOvf = 1'b0;
    endtask

    task automatic idle3();
        bus3.FunSel = 3'b111; bus3.RSel = '0; bus3.TSel = '0; bus3.Input = '0; bus3.ClrOvf = 1'b0;
        bus3.O1Sel = '0; bus3.O2Sel = '0;
    endtask

    initial begin
        // Index map: 0..3 = T1..T4, 4..7 = R1..R4.
        vecs[0]  = '{3'b001, 4'b1000, 4'b0000, 8'hA5, 1'b0, 3'd4, 3'd5, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 4'b1111, 4'b1111, 8'h00, 1'b0, 3'd4, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 4'b1000, 4'b0000, 8'hFF, 1'b0, 3'd4, 3'd4, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 4'b1000, 4'b0000, 8'h00, 1'b0, 3'd4, 3'd4, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{3'b111, 4'b0000, 4'b0000, 8'h00, 1'b1, 3'd4, 3'd5, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{3'b001, 4'b0000, 4'b0100, 8'h81, 1'b0, 3'd1, 3'd4, 8'h81, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 4'b0000, 4'b0100, 8'h00, 1'b0, 3'd1, 3'd4, 8'h03, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 4'b0000, 4'b0100, 8'h00, 1'b0, 3'd1, 3'd4, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 4'b0001, 4'b0000, 8'h00, 1'b0, 3'd7, 3'd1, 8'hFF, 8'h01, 1'b0, 1'b1};
        vecs[9]  = '{3'b100, 4'b0001, 4'b0100, 8'h00, 1'b0, 3'd7, 3'd1, 8'hFE, 8'h02, 1'b0, 1'b1};
        vecs[10] = '{3'b110, 4'b0001, 4'b0000, 8'h00, 1'b0, 3'd7, 3'd1, 8'hFD, 8'h02, 1'b0, 1'b1};
        vecs[11] = '{3'b011, 4'b0001, 4'b0000, 8'h00, 1'b1, 3'd7, 3'd1, 8'hFE, 8'h02, 1'b0, 1'b0};
        vecs[12] = '{3'b010, 4'b0001, 4'b0000, 8'h00, 1'b1, 3'd7, 3'd1, 8'hFD, 8'h02, 1'b0, 1'b0};
        vecs[13] = '{3'b001, 4'b0000, 4'b1000, 8'h00, 1'b0, 3'd0, 3'd7, 8'h00, 8'hFD, 1'b1, 1'b0};
        vecs[14] = '{3'b010, 4'b0000, 4'b1000, 8'h00, 1'b1, 3'd0, 3'd7, 8'hFF, 8'hFD, 1'b0, 1'b1};
        vecs[15] = '{3'b011, 4'b1111, 4'b1111, 8'h00, 1'b0, 3'd0, 3'd1, 8'h00, 8'h03, 1'b1, 1'b1};
        vecs[16] = '{3'b000, 4'b0100, 4'b0000, 8'h00, 1'b1, 3'd5, 3'd6, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[17] = '{3'b001, 4'b1111, 4'b1111, 8'h3C, 1'b0, 3'd7, 3'd7, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[18] = '{3'b111, 4'b0000, 4'b0000, 8'h00, 1'b0, 3'd0, 3'd3, 8'h3C, 8'h3C, 1'b0, 1'b0};

        rst_n = 1'b0;
        idle4();
        idle3();
        bus.O1Sel = '0;
        bus.O2Sel = '0;

        // Reset state on every register.
        #12;
        for (int i = 0; i < 8; i++) begin
            bus.O1Sel = 3'(i);
            bus.O2Sel = 3'(7 - i);
            #1;
            chk($sformatf("rst o1 sel%0d", i), 32'(bus.Output1), 32'h0);
            chk($sformatf("rst o2 sel%0d", 7 - i), 32'(bus.Output2), 32'h0);
            chk($sformatf("rst zero1 sel%0d", i), 32'(bus.Zero1), 32'h1);
        end
        chk("rst ovf", 32'(bus.Ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.FunSel = vecs[i].fs;
            bus.RSel   = vecs[i].rsel;
            bus.TSel   = vecs[i].tsel;
            bus.Input  = vecs[i].din;
            bus.ClrOvf = vecs[i].clr;
            bus.O1Sel  = vecs[i].o1;
            bus.O2Sel  = vecs[i].o2;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d output1", i), 32'(bus.Output1), 32'(vecs[i].e1));
            chk($sformatf("v%0d output2", i), 32'(bus.Output2), 32'(vecs[i].e2));
            chk($sformatf("v%0d zero1", i),   32'(bus.Zero1),   32'(vecs[i].ez));
            chk($sformatf("v%0d ovf", i),     32'(bus.Ovf),     32'(vecs[i].eov));
        end

        // Load R3, then decrement with reset pulsed between edges.
        @(negedge clk);
        bus.FunSel = 3'b001; bus.RSel = 4'b0010; bus.TSel = '0; bus.Input = 8'h10; bus.ClrOvf = 1'b0;
        bus.O1Sel = 3'd6; bus.O2Sel = 3'd6;
        @(posedge clk); #1;
        chk("r3 load", 32'(bus.Output1), 32'h10);
        @(negedge clk);
        bus.FunSel = 3'b010;
        chk("r3 no bypass", 32'(bus.Output1), 32'h10);
        @(posedge clk); #1;
        chk("r3 dec", 32'(bus.Output1), 32'h0F);
        rst_n = 1'b0;
        #1;
        chk("r3 async rst", 32'(bus.Output1), 32'h00);
        chk("r3 async rst o2", 32'(bus.Output2), 32'h00);
        chk("r3 async rst zero1", 32'(bus.Zero1), 32'h1);
        @(posedge clk); #1;
        chk("r3 held in rst", 32'(bus.Output1), 32'h00);
        chk("ovf held in rst", 32'(bus.Ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("r3 first dec after rst", 32'(bus.Output1), 32'hFF);
        chk("ovf first dec after rst", 32'(bus.Ovf), 32'h1);
        @(negedge clk);
        idle4();

        // NR=NT=3 instance: selects 6 and 7 are out of range.
        bus3.FunSel = 3'b001; bus3.RSel = 3'b111; bus3.TSel = 3'b111; bus3.Input = 8'h3C;
        bus3.O1Sel = 3'd6; bus3.O2Sel = 3'd5;
        @(posedge clk); #1;
        chk("n3 oor output1", 32'(bus3.Output1), 32'h00);
        chk("n3 oor zero1", 32'(bus3.Zero1), 32'h1);
        chk("n3 r3 output2", 32'(bus3.Output2), 32'h3C);
        @(negedge clk);
        idle3();
        bus3.O1Sel = 3'd0; bus3.O2Sel = 3'd7;
        #1;
        chk("n3 t1 output1", 32'(bus3.Output1), 32'h3C);
        chk("n3 oor output2", 32'(bus3.Output2), 32'h00);
        chk("n3 zero1 nonzero", 32'(bus3.Zero1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of every register, Input, Output1 and Output2.
REQ-002 Parameter NR, default 4, range 1-8, SHALL set the number of general registers R1..R(NR).
REQ-003 Parameter NT, default 4, range 1-8, SHALL set the number of temporary registers T1..T(NT).
REQ-004 Derived SW = ceil(log2(NR+NT)) SHALL be the width of both read selects.
REQ-005 Clock  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 Reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 Input  in  WIDTH  SHALL be the load data.
REQ-008 FunSel  in  3  SHALL be the operation code applied to every selected register.
REQ-009 RSel  in  NR  SHALL be the one-hot-or-multi write enables; MSB selects R1, LSB selects R(NR).
REQ-010 TSel  in  NT  SHALL be the write enables; MSB selects T1, LSB selects T(NT).
REQ-011 O1Sel, O2Sel  in  SW  SHALL be the read selects; index 0..NT-1 = T1..T(NT), NT..NT+NR-1 = R1..R(NR).
REQ-012 ClrOvf  in  1  SHALL be the synchronous clear of the Ovf flag.
REQ-013 Output1, Output2  out  WIDTH  SHALL be the contents of the registers chosen by O1Sel and O2Sel.
REQ-014 Zero1  out  1  SHALL be high when Output1 equals 0.
REQ-015 Ovf  out  1  SHALL be the sticky wrap-around flag.

Function
REQ-016 On each rising edge, every register whose select bit is 1 SHALL be updated per FunSel; unselected registers SHALL hold.
REQ-017 FunSel 000 SHALL clear to 0; 001 SHALL load Input; 010 SHALL decrement by 1 modulo 2^WIDTH; 011 SHALL increment by 1 modulo 2^WIDTH.
REQ-018 FunSel 100 SHALL shift left logical by 1 (LSB <- 0); 101 SHALL shift right logical by 1 (MSB <- 0); 110 SHALL rotate left by 1; 111 SHALL hold (no update).
REQ-019 Multiple select bits set in the same cycle SHALL apply the same operation independently to each selected register, each using its own prior value.
REQ-020 Read paths SHALL be combinational from register contents; a write SHALL become visible on Output1/Output2 only after the rising edge that performs it (no write-through bypass).
REQ-021 O1Sel or O2Sel >= NR+NT SHALL drive the corresponding output to 0.
REQ-022 Both read ports SHALL be able to select the same register simultaneously and return identical values.
REQ-023 Ovf SHALL set on an edge where any selected register decrements from 0 or increments from 2^WIDTH-1.
REQ-024 Ovf SHALL otherwise hold; ClrOvf=1 SHALL clear it on the edge, except that a simultaneous wrap event SHALL take priority and leave Ovf at 1.
REQ-025 Shift and rotate operations SHALL NOT affect Ovf.
REQ-026 The block SHALL generate no internal strobes or pulses; all sequential logic SHALL be clocked by Clock only.

Reset
REQ-027 Reset=0 SHALL immediately, independent of Clock, force all R and T registers to 0 and Ovf to 0.
REQ-028 During reset, Output1/Output2 SHALL read 0 and Zero1 SHALL read 1 for any valid select.
REQ-029 Reset asserted mid-operation SHALL discard any pending update; the first update after reset deassertion SHALL occur on the next rising edge with Reset=1.

Verification
REQ-030 Reset, RSel=1000, FunSel=001, Input=8'hA5, one edge, O1Sel=4 -> Output1=8'hA5, other registers 0, Zero1=0.
REQ-031 R1=8'hFF, RSel=1000, FunSel=011, one edge -> R1=8'h00, Ovf=1, Zero1=1 with O1Sel=4; next edge with ClrOvf=1, FunSel=111 -> Ovf=0.
REQ-032 T2=8'h81, TSel=0100, FunSel=110 then 101 -> T2=8'h03 then 8'h01; Ovf unchanged.
REQ-033 RSel=1111, TSel=1111, FunSel=001, Input=8'h3C -> all eight registers 8'h3C; O1Sel=O2Sel=7 -> both outputs 8'h3C; O1Sel out of range (WIDTH=8, NR=NT=3, O1Sel=6) -> Output1=0.
REQ-034 R3=8'h10, FunSel=010 held with RSel=0010, Reset pulsed low between edges -> R3 reads 0 immediately; no decrement applied at the reset-coincident edge.
